id_hazard_scoreboard: RTL and testbench

- Parametrised per-register scoreboard beside the ID stage.
- Tracks in-flight destination registers with a remaining-latency countdown.
- Produces the ID stall request for RAW hazards (load-use, multi-cycle div/mul) and WAW ordering hazards.
- Generalises the fixed single-rule load-use stall to N read ports, per-instruction latency and variable-latency units.
- Forwarding data paths stay outside this block; it only decides whether the ID stage may issue.

---
 rtl/id_hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard
//
// Per-register scoreboard that sits beside the ID stage and decides whether
// the decoded instruction may issue. Every in-flight destination register
// carries a pending bit and a remaining-latency countdown. A source operand
// whose producer is still counting down raises a RAW hazard. A write whose
// result would land before an older in-flight write to the same register
// raises a WAW hazard. A countdown of all-ones marks a variable-latency
// producer (divider) that waits for var_done_i.
//
// Ports
//   clk            clock
//   rst            asynchronous active-high reset
//   hold_i         backend stall: freezes countdowns, blocks issue
//   issue_valid_i  ID holds a decoded instruction
//   issue_we_i     instruction writes a register
//   issue_waddr_i  destination register
//   issue_lat_i    cycles until forwardable (all-ones = variable)
//   rd_en_i        per read port "operand is used"
//   rd_addr_i      packed source addresses, port i at [i*AW +: AW]
//   var_done_i     variable-latency result ready
//   var_addr_i     register produced by var_done_i
//   wb_valid_i     writeback commits to the register file
//   wb_addr_i      committed register
//   stallreq_o     ID must stall this cycle (combinational)
//   issue_fire_o   instruction leaves ID this cycle
//   port_hazard_o  per read port RAW hazard
//   busy_cnt_o     number of pending registers (registered)
// -----------------------------------------------------------------------------
module id_hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int CW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              issue_valid_i,
  input  logic              issue_we_i,
  input  logic [AW-1:0]     issue_waddr_i,
  input  logic [CW-1:0]     issue_lat_i,
  input  logic [NRD-1:0]    rd_en_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  input  logic              var_done_i,
  input  logic [AW-1:0]     var_addr_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_addr_i,
  output logic              stallreq_o,
  output logic              issue_fire_o,
  output logic [NRD-1:0]    port_hazard_o,
  output logic [AW:0]       busy_cnt_o
);

  localparam logic [CW-1:0] CNT_VAR = '1;

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [AW:0]     busy_q, busy_d;
  logic            waw_hazard;

  // Hazard lookup compares each address against every tracked register
  // instead of indexing, so NREG < 2^AW never reads past the array.
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    port_hazard_o = '0;
    waw_hazard    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_en_i[i] && rd_addr_i[i*AW +: AW] == AW'(r) &&
            pend_q[r] && cnt_q[r] != '0) begin
          port_hazard_o[i] = 1'b1;
        end
      end
    end
    // An older write still further out than the new one would overwrite the
    // newer result; all-ones is numerically the largest count already.
    for (int r = 1; r < NREG; r++) begin
      if (issue_valid_i && issue_we_i && issue_waddr_i == AW'(r) &&
          pend_q[r] && cnt_q[r] > issue_lat_i) begin
        waw_hazard = 1'b1;
      end
    end
  end

  assign stallreq_o   = issue_valid_i & ((|port_hazard_o) | waw_hazard);
  assign issue_fire_o = issue_valid_i & ~stallreq_o & ~hold_i;
  assign busy_cnt_o   = busy_q;

  // Per-register next state; priority issue > var_done > wb clear > countdown.
  always_comb begin
    pend_d   = '0;
    cnt_d[0] = '0;
    busy_d   = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      cnt_d[r]  = cnt_q[r];
      if (issue_fire_o && issue_we_i && issue_waddr_i == AW'(r)) begin
        pend_d[r] = 1'b1;
        cnt_d[r]  = issue_lat_i;
      end else if (var_done_i && var_addr_i == AW'(r) &&
                   pend_q[r] && cnt_q[r] == CNT_VAR) begin
        cnt_d[r] = '0;
      end else if (wb_valid_i && wb_addr_i == AW'(r)) begin
        pend_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (!hold_i && pend_q[r] &&
                   cnt_q[r] != '0 && cnt_q[r] != CNT_VAR) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
      busy_d = busy_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  // NOTE: the countdown array is a handful of flops, not a RAM, so it is
  // reset like any other state; a reset mid-operation must drop all hazards.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_id_hazard_scoreboard
//
// Directed scenarios (load-use, zero-latency, variable divide, hold,
// simultaneous issue/writeback, WAW and asynchronous reset) followed by a
// randomized phase checked against a reference model. The model keeps one
// remaining-latency integer per register (-1 = waiting for the divider) and
// evaluates the hazard rules directly from those numbers.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_id_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int CW   = 3;
  localparam int VAR  = -1;
  localparam int NRAND = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              issue_valid, issue_we;
  logic [AW-1:0]     issue_waddr;
  logic [CW-1:0]     issue_lat;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic              var_done;
  logic [AW-1:0]     var_addr;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic              stallreq, issue_fire;
  logic [NRD-1:0]    port_hazard;
  logic [AW:0]       busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit m_pend [NREG];
  int m_rem  [NREG];

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold_i        (hold),
    .issue_valid_i (issue_valid),
    .issue_we_i    (issue_we),
    .issue_waddr_i (issue_waddr),
    .issue_lat_i   (issue_lat),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .var_done_i    (var_done),
    .var_addr_i    (var_addr),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .stallreq_o    (stallreq),
    .issue_fire_o  (issue_fire),
    .port_hazard_o (port_hazard),
    .busy_cnt_o    (busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hold = 0; issue_valid = 0; issue_we = 0; issue_waddr = '0; issue_lat = '0;
    rd_en = '0; rd_addr = '0; var_done = 0; var_addr = '0;
    wb_valid = 0; wb_addr = '0;
  endtask

  task automatic issue(input int wa, input int lat);
    issue_valid = 1; issue_we = 1; issue_waddr = AW'(wa); issue_lat = CW'(lat);
  endtask

  task automatic reader(input logic [NRD-1:0] en, input int a0, input int a1);
    issue_valid = 1; issue_we = 0; rd_en = en;
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  function automatic int m_busy();
    int n = 0;
    for (int r = 1; r < NREG; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  // A producer blocks readers until its remaining latency reaches zero.
  function automatic bit m_raw(input int a);
    return a != 0 && m_pend[a] && m_rem[a] != 0;
  endfunction

  initial begin
    int exp_ph, a0, a1, wa, lat, eff;
    bit exp_waw, exp_stall, exp_fire;

    rst = 1;
    idle();
    #2;
    check("reset_busy", 32'(busy_cnt), 0);
    check("reset_stall", 32'(stallreq), 0);
    @(negedge clk);
    rst = 0;

    // Load-use: lw r5 lat=1, consumer stalls exactly one cycle.
    issue(5, 1);
    #1 check("lu_issue_fire", 32'(issue_fire), 1);
    @(negedge clk);
    issue(9, 0); rd_en = 2'b01; rd_addr = {AW'(0), AW'(5)};
    #1 check("lu_stall", 32'(stallreq), 1);
    check("lu_ph", 32'(port_hazard), 32'b01);
    check("lu_fire_blocked", 32'(issue_fire), 0);
    check("lu_busy", 32'(busy_cnt), 1);
    @(negedge clk);
    #1 check("lu_stall_gone", 32'(stallreq), 0);
    check("lu_fire", 32'(issue_fire), 1);

    // Zero-latency ALU op.
    do_reset();
    issue(3, 0);
    #1 check("zl_fire0", 32'(issue_fire), 1);
    @(negedge clk);
    idle(); reader(2'b10, 0, 3);
    #1 check("zl_stall", 32'(stallreq), 0);
    check("zl_fire", 32'(issue_fire), 1);
    check("zl_busy", 32'(busy_cnt), 1);
    @(negedge clk);
    idle();
    #1 check("zl_busy_hold", 32'(busy_cnt), 1);
    @(negedge clk);
    wb_valid = 1; wb_addr = 3;
    #1 check("zl_busy_wb", 32'(busy_cnt), 1);
    @(negedge clk);
    idle();
    #1 check("zl_busy_clr", 32'(busy_cnt), 0);

    // Variable-latency divide.
    do_reset();
    issue(8, 7);
    #1 check("div_fire", 32'(issue_fire), 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      idle(); reader(2'b01, 8, 0);
      #1 check($sformatf("div_stall_%0d", c), 32'(stallreq), 1);
    end
    @(negedge clk);
    var_done = 1; var_addr = 8;
    #1 check("div_done_cycle", 32'(stallreq), 1);
    @(negedge clk);
    var_done = 0;
    #1 check("div_released", 32'(stallreq), 0);
    check("div_release_fire", 32'(issue_fire), 1);

    // Hold freezes the countdown.
    do_reset();
    issue(2, 3);
    #1 check("hold_issue", 32'(issue_fire), 1);
    @(negedge clk);
    idle(); reader(2'b01, 2, 0);
    #1 check("hold_pre", 32'(stallreq), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      hold = 1;
      #1 check($sformatf("hold_stall_%0d", c), 32'(stallreq), 1);
      check($sformatf("hold_nofire_%0d", c), 32'(issue_fire), 0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      hold = 0;
      #1 check($sformatf("hold_after_%0d", c), 32'(stallreq), 1);
    end
    @(negedge clk);
    #1 check("hold_done", 32'(stallreq), 0);
    check("hold_done_fire", 32'(issue_fire), 1);

    // Simultaneous issue and writeback on r4, then r0 handling.
    do_reset();
    issue(4, 0);
    @(negedge clk);
    idle();
    #1 check("sim_busy_pre", 32'(busy_cnt), 1);
    @(negedge clk);
    issue(4, 2); wb_valid = 1; wb_addr = 4;
    #1 check("sim_fire", 32'(issue_fire), 1);
    @(negedge clk);
    idle(); reader(2'b11, 4, 0);
    #1 check("sim_busy_same", 32'(busy_cnt), 1);
    check("sim_stall_cnt2", 32'(stallreq), 1);
    check("sim_ph", 32'(port_hazard), 32'b01);
    @(negedge clk);
    #1 check("sim_stall_cnt1", 32'(stallreq), 1);
    @(negedge clk);
    #1 check("sim_stall_cnt0", 32'(stallreq), 0);
    @(negedge clk);
    idle(); issue(0, 5); rd_en = 2'b11; rd_addr = '0;
    #1 check("r0_fire", 32'(issue_fire), 1);
    check("r0_ph", 32'(port_hazard), 0);
    @(negedge clk);
    idle(); reader(2'b11, 0, 0);
    #1 check("r0_busy", 32'(busy_cnt), 1);
    check("r0_read_stall", 32'(stallreq), 0);

    // WAW and asynchronous reset mid-cycle.
    do_reset();
    issue(6, 5);
    @(negedge clk);
    issue(6, 1);
    #1 check("waw_stall", 32'(stallreq), 1);
    check("waw_nofire", 32'(issue_fire), 0);
    check("waw_busy", 32'(busy_cnt), 1);
    #2 rst = 1;
    #1 check("arst_stall", 32'(stallreq), 0);
    check("arst_busy", 32'(busy_cnt), 0);
    @(negedge clk);
    rst = 0;
    idle();

    // Randomized phase against the reference model, starting from reset.
    for (int r = 0; r < NREG; r++) begin
      m_pend[r] = 0;
      m_rem[r]  = 0;
    end
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      hold        = ($urandom_range(0, 4) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_we    = ($urandom_range(0, 3) != 0);
      wa          = $urandom_range(0, 7);
      lat         = $urandom_range(0, 7);
      issue_waddr = AW'(wa);
      issue_lat   = CW'(lat);
      rd_en       = NRD'($urandom_range(0, 3));
      a0          = $urandom_range(0, 7);
      a1          = $urandom_range(0, 7);
      rd_addr     = {AW'(a1), AW'(a0)};
      var_done    = ($urandom_range(0, 5) == 0);
      var_addr    = AW'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 3) == 0);
      wb_addr     = AW'($urandom_range(0, 7));

      exp_ph = 0;
      if (rd_en[0] && m_raw(a0)) exp_ph |= 1;
      if (rd_en[1] && m_raw(a1)) exp_ph |= 2;
      // The divider's open-ended latency outranks any fixed latency.
      eff = (m_rem[wa] == VAR) ? (1 << CW) - 1 : m_rem[wa];
      exp_waw   = issue_valid && issue_we && wa != 0 && m_pend[wa] && eff > lat;
      exp_stall = issue_valid && (exp_ph != 0 || exp_waw);
      exp_fire  = issue_valid && !exp_stall && !hold;

      #1;
      check($sformatf("rnd%0d_busy", c), 32'(busy_cnt), 32'(m_busy()));
      check($sformatf("rnd%0d_ph", c), 32'(port_hazard), 32'(exp_ph));
      check($sformatf("rnd%0d_stall", c), 32'(stallreq), 32'(exp_stall));
      check($sformatf("rnd%0d_fire", c), 32'(issue_fire), 32'(exp_fire));

      // Advance the model by one clock.
      for (int r = 1; r < NREG; r++) begin
        if (exp_fire && issue_we && wa == r) begin
          m_pend[r] = 1;
          m_rem[r]  = (lat == (1 << CW) - 1) ? VAR : lat;
        end else if (var_done && int'(var_addr) == r && m_pend[r] && m_rem[r] == VAR) begin
          m_rem[r] = 0;
        end else if (wb_valid && int'(wb_addr) == r) begin
          m_pend[r] = 0;
          m_rem[r]  = 0;
        end else if (!hold && m_pend[r] && m_rem[r] > 0) begin
          m_rem[r] = m_rem[r] - 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
